mastermind_board_scorer: RTL and testbench
==========================================

# mastermind_board_scorer

Parametrised guess board and scoring engine for the Mastermind/Wordle game. It accepts a complete guess over a valid/ready handshake and scores it against a latched answer with a sequential exact/partial-match FSM. It then stores the guess and its feedback in the next board row and declares win or lose. It sits between the game-control FSM and the VGA renderer and replaces the fixed 6×12-bit matrix, which had no scoring.

## Interface
- `N_PEGS`, 4: pegs per row.
- `COLOR_W`, 3: bits per peg. Code 0 means empty.
- `N_COLORS`, 6: legal colour codes are 1..`N_COLORS`. Must be ≤ 2^`COLOR_W`−1.
- `N_ROWS`, 6: board depth, i.e. the maximum number of guesses.
- Derived: `CNT_W` = clog2(`N_PEGS`+1), `ROW_W` = clog2(`N_ROWS`+1).
- `Clk`  in  1  system clock; all logic on the rising edge.
- `Reset_n`  in  1  asynchronous, active-low reset.
- `clear`  in  1  synchronous new-game pulse.
- `answer`  in  `N_PEGS`*`COLOR_W`  secret code. Peg i is at [i*`COLOR_W` +: `COLOR_W`].
- `guess`  in  `N_PEGS`*`COLOR_W`  candidate guess, same packing as `answer`.
- `guess_valid`  in  1  guess offered.
- `guess_ready`  out  1  engine can accept a guess.
- `guess_err`  out  1  one-cycle pulse when an accepted-handshake guess is rejected.
- `result_valid`  out  1  one-cycle pulse when a row has been scored and written.
- `exact_cnt`, `partial_cnt`  out  `CNT_W` each  score of the last row.
- `row_count`  out  `ROW_W`  number of rows written.
- `board_flat`  out  `N_ROWS`*`N_PEGS`*`COLOR_W`  row r is at [r*`N_PEGS`*`COLOR_W` +: …].
- `fb_flat`  out  `N_ROWS`*2*`CNT_W`  per row {partial, exact}.
- `win`, `lose`  out  1 each  sticky game-over flags.

## Operation
- States are IDLE, EXACT, COLOR, WRITE and DONE.
- **IDLE**
  - `guess_ready` = 1.
  - On `guess_valid`, if any guess peg is 0 or > `N_COLORS`: pulse `guess_err`, stay in IDLE, change nothing.
  - Otherwise latch the guess and answer snapshots, clear the histograms, exact accumulator and total accumulator, and go to EXACT.
  - Later changes to `answer` do not affect the score in progress.
- **EXACT** (`N_PEGS` cycles, peg index i = 0..`N_PEGS`−1)
  - exact += (g[i]==a[i]).
  - hist_g[g[i]]++ and hist_a[a[i]]++ in the same cycle.
- **COLOR** (`N_COLORS` cycles, c = 1..`N_COLORS`): total += min(hist_g[c], hist_a[c]).
- **WRITE** (1 cycle)
  - board[row_count] ← guess; fb[row_count] ← {total−exact, exact}.
  - `exact_cnt`/`partial_cnt` are updated.
  - row_count++ and `result_valid` pulses.
  - If exact==`N_PEGS`, set `win` and go to DONE.
  - Else if the new row_count==`N_ROWS`, set `lose` and go to DONE.
  - Else go to IDLE.
- **DONE**: `guess_ready` = 0; `guess_valid` is ignored.
- **`clear`** (any state, highest priority after reset)
  - Zero the board, feedback, counts, row_count, `win` and `lose`; go to IDLE.
  - An in-flight score is discarded, with no write and no `result_valid`.
  - `clear` together with an accepting `guess_valid` drops the guess.
- `win` and `lose` are never both 1.
- Unwritten rows read as 0, which the renderer shows as gray.

## Timing
- Reset values:
  - All outputs 0 except `guess_ready` = 1.
  - State IDLE; board and feedback all zero.
- Handshake
  - A guess is accepted at the edge where `guess_valid` && `guess_ready`.
  - `guess_ready` drops the following cycle and stays low until return to IDLE.
- Latency
  - Acceptance edge T to the `result_valid` edge is `N_PEGS`+`N_COLORS`+1 cycles: 11 at the defaults.
  - `guess_ready` is 1 again the cycle after `result_valid`, unless the game is over.
- `guess_err` is asserted the cycle after the offending handshake edge.
- Board outputs, `row_count` and the counts change only at the WRITE edge; they are stable otherwise.
- Assertion of `Reset_n` mid-score aborts immediately and clears everything asynchronously.

## Structure
- Shared package `mastermind_pkg`:
  - `COLOR_EMPTY` = 0.
  - Default values of `N_PEGS`, `COLOR_W`, `N_COLORS` and `N_ROWS`.
  - State encoding constants.
  - A peg-extract function.
- One sub-module, `mastermind_row_store`: row-indexed write, flat read-out and synchronous clear for the board and feedback arrays.
- Scoring FSM, histograms and handshake live in the top of this block.

## Test plan
- Answer {1,1,1,1}, guess {1,1,1,1} → `result_valid` 11 cycles after acceptance, exact=4, partial=0, `win`=1, `guess_ready` stays 0.
- Answer {1,2,3,4}, guess {4,3,2,1} → exact=0, partial=4, row_count=1, row 0 of `board_flat` holds the guess.
- Answer {1,1,2,2}, guess {1,2,1,3} → exact=1, partial=2.
- Six non-winning guesses → `lose`=1 on the 6th `result_valid`, row_count=6, and a 7th `guess_valid` is ignored.
- Guess {0,1,1,1} or {7,1,1,1} → `guess_err` pulse, row_count unchanged, `guess_ready`=1.
- `clear` 5 cycles after acceptance → no `result_valid`, all rows 0, row_count=0. Repeat with a `Reset_n` low pulse mid-score → same result, with outputs at reset values asynchronously.

Source files
------------

// File: rtl/mastermind_pkg.sv
// -----------------------------------------------------------------------------
// mastermind_pkg
// Shared definitions for the Mastermind guess board and scoring engine:
//   - default geometry (pegs per row, bits per peg, colour count, board depth)
//   - the empty-peg colour code
//   - scoring FSM state encoding
//   - peg_at(): extract one peg from a packed code vector
// -----------------------------------------------------------------------------
package mastermind_pkg;

  localparam int N_PEGS_DEF   = 4;
  localparam int COLOR_W_DEF  = 3;
  localparam int N_COLORS_DEF = 6;
  localparam int N_ROWS_DEF   = 6;

  // Colour code 0 is "no peg"; the renderer shows it as gray.
  localparam int COLOR_EMPTY = 0;

  // Widest packed code and widest peg peg_at() can handle.
  localparam int PEG_VEC_W = 256;
  localparam int PEG_MAX_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_EXACT = 3'd1,
    ST_COLOR = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Peg idx of a packed code lives at [idx*color_w +: color_w].
  function automatic logic [PEG_MAX_W-1:0] peg_at(
    input logic [PEG_VEC_W-1:0] vec,
    input int unsigned          idx,
    input int unsigned          color_w
  );
    logic [PEG_VEC_W-1:0] shifted;
    logic [PEG_MAX_W-1:0] mask;
    shifted = vec >> (idx * color_w);
    mask    = PEG_MAX_W'((1 << color_w) - 1);
    return shifted[PEG_MAX_W-1:0] & mask;
  endfunction

endpackage

// File: rtl/mastermind_row_store.sv
// -----------------------------------------------------------------------------
// mastermind_row_store
// Board and feedback storage: one row written per scored guess, every row
// visible at once on flat buses for the renderer, whole board zeroed by clear.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   clear             synchronous wipe of every row (wins over a write)
//   wr_en, wr_row     write strobe and target row
//   wr_guess, wr_fb   row contents: the guess and its {partial, exact} score
//   board_flat        row r at [r*N_PEGS*COLOR_W +: N_PEGS*COLOR_W]
//   fb_flat           row r at [r*2*CNT_W +: 2*CNT_W]
// -----------------------------------------------------------------------------
module mastermind_row_store
  import mastermind_pkg::*;
#(
  parameter int N_PEGS  = N_PEGS_DEF,
  parameter int COLOR_W = COLOR_W_DEF,
  parameter int N_ROWS  = N_ROWS_DEF,
  parameter int CNT_W   = $clog2(N_PEGS_DEF + 1),
  parameter int ROW_W   = $clog2(N_ROWS_DEF + 1)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              clear,
  input  logic                              wr_en,
  input  logic [ROW_W-1:0]                  wr_row,
  input  logic [N_PEGS*COLOR_W-1:0]         wr_guess,
  input  logic [2*CNT_W-1:0]                wr_fb,
  output logic [N_ROWS*N_PEGS*COLOR_W-1:0]  board_flat,
  output logic [N_ROWS*2*CNT_W-1:0]         fb_flat
);

  localparam int ROW_BITS = N_PEGS * COLOR_W;
  localparam int FB_BITS  = 2 * CNT_W;

  logic [ROW_BITS-1:0] board_q [N_ROWS];
  logic [ROW_BITS-1:0] board_d [N_ROWS];
  logic [FB_BITS-1:0]  fb_q    [N_ROWS];
  logic [FB_BITS-1:0]  fb_d    [N_ROWS];

  always_comb begin
    // NOTE: every _d starts as a copy of its _q so no path leaves it unassigned,
    // which would otherwise infer a latch.
    board_d = board_q;
    fb_d    = fb_q;
    for (int r = 0; r < N_ROWS; r++) begin
      if (clear) begin
        board_d[r] = '0;
        fb_d[r]    = '0;
      end else if (wr_en && (wr_row == ROW_W'(r))) begin
        board_d[r] = wr_guess;
        fb_d[r]    = wr_fb;
      end
    end
  end

  // NOTE: this array is reset, unlike a RAM, because unwritten rows must read
  // as zero straight out of reset; that forces it into flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < N_ROWS; r++) begin
        board_q[r] <= '0;
        fb_q[r]    <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      board_q <= board_d;
      fb_q    <= fb_d;
    end
  end

  for (genvar r = 0; r < N_ROWS; r++) begin : g_flat
    assign board_flat[r*ROW_BITS +: ROW_BITS] = board_q[r];
    assign fb_flat[r*FB_BITS +: FB_BITS]      = fb_q[r];
  end

endmodule

// File: rtl/mastermind_board_scorer.sv
// -----------------------------------------------------------------------------
// mastermind_board_scorer
// Accepts a guess over valid/ready, scores it against a snapshot of the answer
// (exact pass over the pegs, then a per-colour min() pass over histograms),
// writes guess and feedback into the next board row and flags win / lose.
// Ports:
//   Clk, Reset_n                 clock, asynchronous active-low reset
//   clear                        synchronous new-game pulse (aborts scoring)
//   answer, guess                packed codes, peg i at [i*COLOR_W +: COLOR_W]
//   guess_valid / guess_ready    guess handshake
//   guess_err                    pulse: offered guess had an illegal peg
//   result_valid                 pulse: row scored and written
//   exact_cnt, partial_cnt       score of the last written row
//   row_count                    rows written this game
//   board_flat, fb_flat          whole board and {partial, exact} per row
//   win, lose                    sticky game-over flags
// -----------------------------------------------------------------------------
module mastermind_board_scorer
  import mastermind_pkg::*;
#(
  parameter int  N_PEGS   = N_PEGS_DEF,
  parameter int  COLOR_W  = COLOR_W_DEF,
  parameter int  N_COLORS = N_COLORS_DEF,  // must be <= 2**COLOR_W - 1
  parameter int  N_ROWS   = N_ROWS_DEF,
  localparam int CNT_W    = $clog2(N_PEGS + 1),
  localparam int ROW_W    = $clog2(N_ROWS + 1)
) (
  input  logic                              Clk,
  input  logic                              Reset_n,
  input  logic                              clear,
  input  logic [N_PEGS*COLOR_W-1:0]         answer,
  input  logic [N_PEGS*COLOR_W-1:0]         guess,
  input  logic                              guess_valid,
  output logic                              guess_ready,
  output logic                              guess_err,
  output logic                              result_valid,
  output logic [CNT_W-1:0]                  exact_cnt,
  output logic [CNT_W-1:0]                  partial_cnt,
  output logic [ROW_W-1:0]                  row_count,
  output logic [N_ROWS*N_PEGS*COLOR_W-1:0]  board_flat,
  output logic [N_ROWS*2*CNT_W-1:0]         fb_flat,
  output logic                              win,
  output logic                              lose
);

  localparam int CODE_W   = N_PEGS * COLOR_W;
  // Histograms cover every code the answer bus can carry, legal or not.
  localparam int N_CODES  = 2 ** COLOR_W;
  localparam int STEP_MAX = (N_PEGS > N_COLORS) ? N_PEGS : N_COLORS;
  localparam int STEP_W   = $clog2(STEP_MAX + 1);

  state_e              state_q, state_d;
  logic [STEP_W-1:0]   step_q, step_d;         // peg index in EXACT, colour in COLOR
  logic [CODE_W-1:0]   guess_q, guess_d;
  logic [CODE_W-1:0]   answer_q, answer_d;
  logic [CNT_W-1:0]    hist_g_q [N_CODES];
  logic [CNT_W-1:0]    hist_g_d [N_CODES];
  logic [CNT_W-1:0]    hist_a_q [N_CODES];
  logic [CNT_W-1:0]    hist_a_d [N_CODES];
  logic [CNT_W-1:0]    exact_acc_q, exact_acc_d;
  logic [CNT_W-1:0]    total_acc_q, total_acc_d;
  logic [CNT_W-1:0]    exact_cnt_q, exact_cnt_d;
  logic [CNT_W-1:0]    partial_cnt_q, partial_cnt_d;
  logic [ROW_W-1:0]    row_count_q, row_count_d;
  logic                win_q, win_d;
  logic                lose_q, lose_d;
  logic                guess_err_q, guess_err_d;
  logic                result_valid_q, result_valid_d;

  logic                guess_legal;
  logic [COLOR_W-1:0]  g_peg;
  logic [COLOR_W-1:0]  a_peg;
  logic [COLOR_W-1:0]  c_idx;
  logic [CNT_W-1:0]    min_cnt;
  logic                wr_en;
  logic [2*CNT_W-1:0]  wr_fb;

  // A guess is legal only if every peg is a real colour 1..N_COLORS.
  always_comb begin
    guess_legal = 1'b1;
    for (int p = 0; p < N_PEGS; p++) begin
      if ((32'(peg_at(PEG_VEC_W'(guess), p, COLOR_W)) == COLOR_EMPTY) ||
          (32'(peg_at(PEG_VEC_W'(guess), p, COLOR_W)) > N_COLORS)) begin
        guess_legal = 1'b0;
      end
    end
  end

  // Per-cycle operands of the two scoring passes.
  always_comb begin
    g_peg   = COLOR_W'(peg_at(PEG_VEC_W'(guess_q),  32'(step_q), COLOR_W));
    a_peg   = COLOR_W'(peg_at(PEG_VEC_W'(answer_q), 32'(step_q), COLOR_W));
    c_idx   = COLOR_W'(step_q);
    min_cnt = (hist_g_q[c_idx] < hist_a_q[c_idx]) ? hist_g_q[c_idx] : hist_a_q[c_idx];
  end

  always_comb begin
    state_d        = state_q;
    step_d         = step_q;
    guess_d        = guess_q;
    answer_d       = answer_q;
    hist_g_d       = hist_g_q;
    hist_a_d       = hist_a_q;
    exact_acc_d    = exact_acc_q;
    total_acc_d    = total_acc_q;
    exact_cnt_d    = exact_cnt_q;
    partial_cnt_d  = partial_cnt_q;
    row_count_d    = row_count_q;
    win_d          = win_q;
    lose_d         = lose_q;
    guess_err_d    = 1'b0;
    result_valid_d = 1'b0;
    wr_en          = 1'b0;
    // Total matches minus exact matches are the right-colour-wrong-place pegs.
    wr_fb          = {total_acc_q - exact_acc_q, exact_acc_q};
    guess_ready    = (state_q == ST_IDLE);

    unique case (state_q)
      ST_IDLE: begin
        if (guess_valid) begin
          if (!guess_legal) begin
            guess_err_d = 1'b1;
          end else begin
            // Snapshot both codes so later answer changes cannot skew the score.
            guess_d     = guess;
            answer_d    = answer;
            for (int c = 0; c < N_CODES; c++) begin
              hist_g_d[c] = '0;
              hist_a_d[c] = '0;
            end
            exact_acc_d = '0;
            total_acc_d = '0;
            step_d      = '0;
            state_d     = ST_EXACT;
          end
        end
      end

      ST_EXACT: begin
        exact_acc_d     = exact_acc_q + CNT_W'(g_peg == a_peg);
        hist_g_d[g_peg] = hist_g_q[g_peg] + CNT_W'(1);
        hist_a_d[a_peg] = hist_a_q[a_peg] + CNT_W'(1);
        if (32'(step_q) == N_PEGS - 1) begin
          step_d  = STEP_W'(1);             // colour pass starts at code 1
          state_d = ST_COLOR;
        end else begin
          step_d  = step_q + STEP_W'(1);
        end
      end

      ST_COLOR: begin
        total_acc_d = total_acc_q + min_cnt;
        if (32'(step_q) == N_COLORS) begin
          state_d = ST_WRITE;
        end else begin
          step_d  = step_q + STEP_W'(1);
        end
      end

      ST_WRITE: begin
        wr_en          = 1'b1;
        exact_cnt_d    = exact_acc_q;
        partial_cnt_d  = total_acc_q - exact_acc_q;
        row_count_d    = row_count_q + ROW_W'(1);
        result_valid_d = 1'b1;
        if (exact_acc_q == CNT_W'(N_PEGS)) begin
          win_d   = 1'b1;
          state_d = ST_DONE;
        end else if (32'(row_count_d) == N_ROWS) begin
          lose_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_DONE: begin
        guess_ready = 1'b0;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // New game overrides everything, including a write or a handshake this edge.
    if (clear) begin
      state_d        = ST_IDLE;
      step_d         = '0;
      exact_cnt_d    = '0;
      partial_cnt_d  = '0;
      row_count_d    = '0;
      win_d          = 1'b0;
      lose_d         = 1'b0;
      guess_err_d    = 1'b0;
      result_valid_d = 1'b0;
      wr_en          = 1'b0;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q        <= ST_IDLE;
      step_q         <= '0;
      guess_q        <= '0;
      answer_q       <= '0;
      for (int c = 0; c < N_CODES; c++) begin
        hist_g_q[c] <= '0;
        hist_a_q[c] <= '0;
      end
      exact_acc_q    <= '0;
      total_acc_q    <= '0;
      exact_cnt_q    <= '0;
      partial_cnt_q  <= '0;
      row_count_q    <= '0;
      win_q          <= 1'b0;
      lose_q         <= 1'b0;
      guess_err_q    <= 1'b0;
      result_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      step_q         <= step_d;
      guess_q        <= guess_d;
      answer_q       <= answer_d;
      hist_g_q       <= hist_g_d;
      hist_a_q       <= hist_a_d;
      exact_acc_q    <= exact_acc_d;
      total_acc_q    <= total_acc_d;
      exact_cnt_q    <= exact_cnt_d;
      partial_cnt_q  <= partial_cnt_d;
      row_count_q    <= row_count_d;
      win_q          <= win_d;
      lose_q         <= lose_d;
      guess_err_q    <= guess_err_d;
      result_valid_q <= result_valid_d;
    end
  end

  mastermind_row_store #(
    .N_PEGS  (N_PEGS),
    .COLOR_W (COLOR_W),
    .N_ROWS  (N_ROWS),
    .CNT_W   (CNT_W),
    .ROW_W   (ROW_W)
  ) u_row_store (
    .clk        (Clk),
    .rst_n      (Reset_n),
    .clear      (clear),
    .wr_en      (wr_en),
    .wr_row     (row_count_q),
    .wr_guess   (guess_q),
    .wr_fb      (wr_fb),
    .board_flat (board_flat),
    .fb_flat    (fb_flat)
  );

  assign guess_err    = guess_err_q;
  assign result_valid = result_valid_q;
  assign exact_cnt    = exact_cnt_q;
  assign partial_cnt  = partial_cnt_q;
  assign row_count    = row_count_q;
  assign win          = win_q;
  assign lose         = lose_q;

endmodule

// File: tb/tb_mastermind_board_scorer.sv
// -----------------------------------------------------------------------------
// tb_mastermind_board_scorer
// Directed scenarios plus randomized games against a reference model that
// scores codes the way a human player marks pegs (exact first, then pairing
// each remaining guess peg with an unused answer peg of the same colour).
// -----------------------------------------------------------------------------
module tb_mastermind_board_scorer;

  localparam int NP     = 4;
  localparam int CW     = 3;
  localparam int NC     = 6;
  localparam int NR     = 6;
  localparam int CNT_W  = 3;
  localparam int ROW_W  = 3;
  localparam int CODE_W = NP * CW;
  localparam int LAT    = NP + NC + 1;

  logic                     Clk = 1'b0;
  logic                     Reset_n;
  logic                     clear;
  logic [CODE_W-1:0]        answer;
  logic [CODE_W-1:0]        guess;
  logic                     guess_valid;
  logic                     guess_ready;
  logic                     guess_err;
  logic                     result_valid;
  logic [CNT_W-1:0]         exact_cnt;
  logic [CNT_W-1:0]         partial_cnt;
  logic [ROW_W-1:0]         row_count;
  logic [NR*CODE_W-1:0]     board_flat;
  logic [NR*2*CNT_W-1:0]    fb_flat;
  logic                     win;
  logic                     lose;

  mastermind_board_scorer #(
    .N_PEGS(NP), .COLOR_W(CW), .N_COLORS(NC), .N_ROWS(NR)
  ) dut (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .clear        (clear),
    .answer       (answer),
    .guess        (guess),
    .guess_valid  (guess_valid),
    .guess_ready  (guess_ready),
    .guess_err    (guess_err),
    .result_valid (result_valid),
    .exact_cnt    (exact_cnt),
    .partial_cnt  (partial_cnt),
    .row_count    (row_count),
    .board_flat   (board_flat),
    .fb_flat      (fb_flat),
    .win          (win),
    .lose         (lose)
  );

  always #5 Clk = ~Clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [CODE_W-1:0] m_board [NR];
  int                m_exact [NR];
  int                m_part  [NR];
  int                m_rows;
  int                m_last_exact;
  int                m_last_part;
  bit                m_win;
  bit                m_lose;

  function automatic logic [CODE_W-1:0] pack4(input int p0, input int p1, input int p2, input int p3);
    return {3'(p3), 3'(p2), 3'(p1), 3'(p0)};
  endfunction

  function automatic logic [CODE_W-1:0] rand_code();
    return pack4($urandom_range(1, NC), $urandom_range(1, NC),
                 $urandom_range(1, NC), $urandom_range(1, NC));
  endfunction

  function automatic void ref_score(input logic [CODE_W-1:0] a, input logic [CODE_W-1:0] g,
                                    output int ex, output int pa);
    int av [NP];
    int gv [NP];
    bit a_used [NP];
    bit g_used [NP];
    bit found;
    ex = 0;
    pa = 0;
    for (int i = 0; i < NP; i++) begin
      av[i] = int'(a[i*CW +: CW]);
      gv[i] = int'(g[i*CW +: CW]);
      a_used[i] = 1'b0;
      g_used[i] = 1'b0;
    end
    for (int i = 0; i < NP; i++) begin
      if (gv[i] == av[i]) begin
        ex++;
        a_used[i] = 1'b1;
        g_used[i] = 1'b1;
      end
    end
    for (int i = 0; i < NP; i++) begin
      found = 1'b0;
      for (int j = 0; j < NP; j++) begin
        if (!g_used[i] && !found && !a_used[j] && gv[i] == av[j]) begin
          a_used[j] = 1'b1;
          found = 1'b1;
          pa++;
        end
      end
    end
  endfunction

  task automatic model_reset();
    m_rows = 0;
    m_win = 1'b0;
    m_lose = 1'b0;
    m_last_exact = 0;
    m_last_part = 0;
    for (int r = 0; r < NR; r++) begin
      m_board[r] = '0;
      m_exact[r] = 0;
      m_part[r] = 0;
    end
  endtask

  task automatic check_board(input string tag);
    logic [NR*CODE_W-1:0]  exp_board;
    logic [NR*2*CNT_W-1:0] exp_fb;
    exp_board = '0;
    exp_fb = '0;
    for (int r = 0; r < NR; r++) begin
      exp_board[r*CODE_W +: CODE_W] = m_board[r];
      exp_fb[r*2*CNT_W +: 2*CNT_W] = {3'(m_part[r]), 3'(m_exact[r])};
    end
    check({tag, ".board"}, board_flat, exp_board);
    check({tag, ".fb"}, fb_flat, exp_fb);
    check({tag, ".row_count"}, row_count, m_rows);
    check({tag, ".exact_cnt"}, exact_cnt, m_last_exact);
    check({tag, ".partial_cnt"}, partial_cnt, m_last_part);
    check({tag, ".win"}, win, m_win);
    check({tag, ".lose"}, lose, m_lose);
  endtask

  // ---------------- stimulus tasks (entered/left at posedge+1) ----------------
  task automatic play(input string tag, input logic [CODE_W-1:0] a, input logic [CODE_W-1:0] g);
    int k;
    int ex;
    int pa;
    check({tag, ".ready_before"}, guess_ready, 1'b1);
    answer = a;
    guess = g;
    guess_valid = 1'b1;
    @(posedge Clk);
    #1;
    guess_valid = 1'b0;
    answer = 12'($urandom);   // must not disturb the score in flight
    guess = 12'($urandom);
    check({tag, ".ready_drop"}, guess_ready, 1'b0);
    k = 0;
    do begin
      @(posedge Clk);
      #1;
      k++;
    end while (!result_valid && k < 3 * LAT);
    check({tag, ".latency"}, k, LAT);
    ref_score(a, g, ex, pa);
    m_board[m_rows] = g;
    m_exact[m_rows] = ex;
    m_part[m_rows] = pa;
    m_last_exact = ex;
    m_last_part = pa;
    m_rows++;
    if (ex == NP) m_win = 1'b1;
    else if (m_rows == NR) m_lose = 1'b1;
    check_board(tag);
    check({tag, ".ready_after"}, guess_ready, !(m_win || m_lose));
    @(posedge Clk);
    #1;
    check({tag, ".rv_pulse"}, result_valid, 1'b0);
  endtask

  task automatic try_bad(input string tag, input logic [CODE_W-1:0] g);
    guess = g;
    answer = rand_code();
    guess_valid = 1'b1;
    @(posedge Clk);
    #1;
    guess_valid = 1'b0;
    check({tag, ".err"}, guess_err, 1'b1);
    check({tag, ".ready"}, guess_ready, 1'b1);
    check({tag, ".row_count"}, row_count, m_rows);
    @(posedge Clk);
    #1;
    check({tag, ".err_pulse"}, guess_err, 1'b0);
  endtask

  task automatic no_result(input string tag, input int n);
    bit seen;
    seen = 1'b0;
    repeat (n) begin
      @(posedge Clk);
      #1;
      if (result_valid || guess_err) seen = 1'b1;
    end
    check({tag, ".no_result"}, seen, 1'b0);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge Clk);
    #1;
    clear = 1'b0;
    model_reset();
  endtask

  task automatic offer_in_done(input string tag);
    guess = rand_code();
    guess_valid = 1'b1;
    no_result(tag, 2 * LAT);
    guess_valid = 1'b0;
    check({tag, ".ready"}, guess_ready, 1'b0);
    check_board(tag);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [CODE_W-1:0] a;
    logic [CODE_W-1:0] g;
    Reset_n = 1'b0;
    clear = 1'b0;
    guess_valid = 1'b0;
    answer = '0;
    guess = '0;
    model_reset();
    #23;
    Reset_n = 1'b1;
    @(posedge Clk);
    #1;
    check("reset.ready", guess_ready, 1'b1);
    check("reset.result_valid", result_valid, 1'b0);
    check("reset.guess_err", guess_err, 1'b0);
    check_board("reset");

    // Immediate win.
    play("win", pack4(1, 1, 1, 1), pack4(1, 1, 1, 1));
    offer_in_done("win_done");

    // All colours right, all misplaced; then a repeated-colour case.
    do_clear();
    check_board("clear1");
    play("perm", pack4(1, 2, 3, 4), pack4(4, 3, 2, 1));
    play("dup", pack4(1, 1, 2, 2), pack4(1, 2, 1, 3));

    // Illegal guesses.
    try_bad("bad0", pack4(0, 1, 1, 1));
    try_bad("bad7", pack4(7, 1, 1, 1));
    check_board("after_bad");

    // Six misses lose the game; a seventh offer is ignored.
    do_clear();
    a = pack4(1, 2, 3, 4);
    for (int i = 0; i < NR; i++) begin
      do g = rand_code(); while (g == a);
      play($sformatf("lose%0d", i), a, g);
    end
    offer_in_done("lose_done");

    // clear five cycles into a score: nothing written, board wiped.
    do_clear();
    play("pre_clr0", rand_code(), rand_code());
    play("pre_clr1", rand_code(), rand_code());
    answer = rand_code();
    guess = rand_code();
    guess_valid = 1'b1;
    @(posedge Clk);
    #1;
    guess_valid = 1'b0;
    repeat (4) @(posedge Clk);
    #1;
    clear = 1'b1;
    @(posedge Clk);
    #1;
    clear = 1'b0;
    model_reset();
    check("clr_mid.ready", guess_ready, 1'b1);
    no_result("clr_mid", 2 * LAT);
    check_board("clr_mid");

    // clear on the same edge as an accepting handshake drops the guess.
    play("pre_clr_hs", rand_code(), rand_code());
    guess = rand_code();
    guess_valid = 1'b1;
    clear = 1'b1;
    @(posedge Clk);
    #1;
    guess_valid = 1'b0;
    clear = 1'b0;
    model_reset();
    check("clr_hs.ready", guess_ready, 1'b1);
    no_result("clr_hs", 2 * LAT);
    check_board("clr_hs");

    // Reset_n pulse mid-score clears outputs without waiting for a clock edge.
    play("pre_rst", rand_code(), rand_code());
    guess = rand_code();
    guess_valid = 1'b1;
    @(posedge Clk);
    #1;
    guess_valid = 1'b0;
    repeat (4) @(posedge Clk);
    #2;
    Reset_n = 1'b0;
    #1;
    model_reset();
    check("rst_mid.ready", guess_ready, 1'b1);
    check("rst_mid.result_valid", result_valid, 1'b0);
    check_board("rst_mid");
    @(negedge Clk);
    Reset_n = 1'b1;
    no_result("rst_mid", 2 * LAT);
    check_board("rst_after");

    // Randomized games.
    for (int gm = 0; gm < 8; gm++) begin
      do_clear();
      a = rand_code();
      while (!m_win && !m_lose) begin
        g = ($urandom_range(0, 4) == 0) ? a : rand_code();
        play($sformatf("rg%0d_r%0d", gm, m_rows), a, g);
      end
      if (gm % 3 == 0) offer_in_done($sformatf("rg%0d_done", gm));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
